display_update_ctrl: RTL

DISPLAY_UPDATE_CTRL -- requirements
Module: display_update_ctrl

---
 rtl/display_update_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/display_update_ctrl.sv
// display_update_ctrl
// Two-requester front end for a 4-digit BCD display. Requesters hand over
// 14-bit binary values through a round-robin valid/ready handshake. Values
// above 9999 are clamped, and the result is converted to packed BCD by a
// sequential double-dabble engine at one shift per cycle. The new value is
// then held on the display for HOLD_CYCLES cycles before another request
// is accepted.
module display_update_ctrl #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [13:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [13:0] req1_data,
  output logic        req1_ready,
  output logic [15:0] bcd_data,
  output logic        bcd_update,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // The hold counter counts down from HOLD_CYCLES-1 to zero. It keeps a
  // width of at least one bit so that HOLD_CYCLES of 0 or 1 still elaborates.
  localparam int              CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [3:0]      LAST_ITER = 4'd13;
  localparam logic [13:0]     MAX_VALUE = 14'd9999;

  // Double-dabble working register: [29:14] holds four BCD digits and
  // [13:0] holds the binary bits that have not yet been shifted in.
  state_t           r_state;
  logic             r_lastServed;
  logic [29:0]      r_shift;
  logic [3:0]       r_iter;
  logic [CNT_W-1:0] r_holdCnt;
  logic [15:0]      r_bcdData;
  logic             r_bcdUpdate;
  logic             r_overflow;

  logic             w_idle;
  logic             w_grant;
  logic             w_handshake;
  logic [13:0]      w_grantData;
  logic             w_isOver;
  logic [13:0]      w_clamped;
  logic [29:0]      w_adjusted;
  logic [29:0]      w_shiftNext;

  assign w_idle = (r_state == IDLE);

  // Round-robin grant. A lone valid requester wins. On a tie the requester
  // not served last wins. With no valid requester the grant parks on the
  // one that would win the next tie.
  always_comb begin
    w_grant = ~r_lastServed;
    if (req0_valid && !req1_valid) begin
      w_grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      w_grant = 1'b1;
    end
  end

  assign req0_ready  = w_idle && !w_grant;
  assign req1_ready  = w_idle &&  w_grant;
  assign w_handshake = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign w_grantData = w_grant ? req1_data : req0_data;
  assign w_isOver    = (w_grantData > MAX_VALUE);
  assign w_clamped   = w_isOver ? MAX_VALUE : w_grantData;

  // One double-dabble iteration: add 3 to any BCD digit of 5 or more,
  // then shift the whole register left by one bit.
  always_comb begin
    w_adjusted = r_shift;
    for (int d = 0; d < 4; d++) begin
      if (r_shift[14 + 4*d +: 4] > 4'd4) begin
        w_adjusted[14 + 4*d +: 4] = r_shift[14 + 4*d +: 4] + 4'd3;
      end
    end
    w_shiftNext = w_adjusted << 1;
  end

  // Control FSM: handles capture and clamping on the handshake, fourteen
  // conversion steps, the display load with a one-cycle update pulse, and
  // the hold period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_lastServed <= 1'b1;
      r_shift      <= '0;
      r_iter       <= '0;
      r_holdCnt    <= '0;
      r_bcdData    <= '0;
      r_bcdUpdate  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_bcdUpdate <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_handshake) begin
            r_lastServed <= w_grant;
            r_overflow   <= w_isOver;
            r_shift      <= {16'd0, w_clamped};
            r_iter       <= '0;
            r_state      <= CONVERT;
          end
        end
        CONVERT: begin
          r_shift <= w_shiftNext;
          if (r_iter == LAST_ITER) begin
            r_bcdData   <= w_shiftNext[29:14];
            r_bcdUpdate <= 1'b1;
            if (HOLD_CYCLES == 0) begin
              r_state <= IDLE;
            end else begin
              r_holdCnt <= HOLD_LOAD;
              r_state   <= HOLD;
            end
          end else begin
            r_iter <= r_iter + 4'd1;
          end
        end
        HOLD: begin
          if (r_holdCnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_holdCnt <= r_holdCnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bcd_data   = r_bcdData;
  assign bcd_update = r_bcdUpdate;
  assign overflow   = r_overflow;
  assign busy       = !w_idle;

endmodule
